// File: rtl/hist_mm_master_pkg.sv
// Shared types for the histogram-RAM Avalon-MM self-test initiator.
package hist_mm_pkg;

    typedef enum logic [2:0] {
        st_idle,
        st_write,
        st_read,
        st_drain,
        st_done
    } state_t;

    typedef enum logic {
        OP_FILL  = 1'b0,
        OP_CHECK = 1'b1
    } op_t;

    localparam int unsigned WORD_STRIDE = 4;

endpackage

// File: rtl/hist_mm_master_if.sv
// Command/result handshake plus Avalon-MM initiator bus for hist_mm_master.
interface hist_mm_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_op;
    logic [ADDR_W-1:0]     cmd_base;
    logic [CNT_W-1:0]      cmd_count;
    logic [DATA_W-1:0]     cmd_seed;
    logic                  busy;
    logic                  done;
    logic [DATA_W-1:0]     done_sum;
    logic [CNT_W-1:0]      done_errors;

    logic [ADDR_W-1:0]     m_address;
    logic                  m_read;
    logic                  m_write;
    logic [DATA_W-1:0]     m_writedata;
    logic [DATA_W/8-1:0]   m_byteenable;
    logic                  m_waitrequest;
    logic [DATA_W-1:0]     m_readdata;
    logic                  m_readdatavalid;

    modport master (
        input  cmd_valid, cmd_op, cmd_base, cmd_count, cmd_seed,
        output cmd_ready, busy, done, done_sum, done_errors,
        output m_address, m_read, m_write, m_writedata, m_byteenable,
        input  m_waitrequest, m_readdata, m_readdatavalid
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_base, cmd_count, cmd_seed,
        input  cmd_ready, busy, done, done_sum, done_errors,
        input  m_address, m_read, m_write, m_writedata, m_byteenable,
        output m_waitrequest, m_readdata, m_readdatavalid
    );
endinterface

// File: rtl/hist_mm_master_outstanding_ctr.sv
// Count of accepted-but-unreturned reads; decrement saturates at zero so a
// stray readdatavalid can never wrap the count.
module mm_outstanding_ctr #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clock,
    input  logic          ctrl_reset,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_next,
    output logic          o_full,
    output logic          o_dec_taken
);
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_next;
    logic          w_dec;

    always_comb begin
        w_dec  = i_dec && (r_count != '0);
        w_next = r_count;
        if (i_inc && !w_dec)
            w_next = r_count + CW'(1);
        else if (!i_inc && w_dec)
            w_next = r_count - CW'(1);
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset)
            r_count <= '0;
        else
            r_count <= w_next;
    end

    assign o_next      = w_next;
    assign o_full      = (r_count == CW'(MAX_OUTSTANDING));
    assign o_dec_taken = w_dec;

endmodule

// File: rtl/hist_mm_master.sv
// Avalon-MM initiator: fills a word range with seed+i, or reads it back with
// bounded pipelining, summing data and counting pattern mismatches.
module hist_mm_master
    import hist_mm_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int CNT_W           = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    hist_mm_master_if.master bus
);
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_errors;
    logic [CNT_W-1:0]    r_done_errors;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_exp;
    logic [DATA_W-1:0]   r_sum;
    logic [DATA_W-1:0]   r_done_sum;
    logic                r_read;
    logic                r_write;
    logic                r_busy;
    logic                r_done;

    logic                w_in_rd;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic                w_rv;
    logic                w_ret;
    logic                w_last;
    logic                w_full;
    logic                w_next_full;
    logic [OCW-1:0]      w_out_next;
    logic [DATA_W-1:0]   w_sum_nxt;
    logic [CNT_W-1:0]    w_err_nxt;

    assign w_in_rd  = (r_state == st_read) || (r_state == st_drain);
    assign w_rd_acc = r_read && !bus.m_waitrequest;
    assign w_wr_acc = r_write && !bus.m_waitrequest;
    assign w_rv     = bus.m_readdatavalid && w_in_rd;
    assign w_last   = (r_idx == r_count - CNT_W'(1));

    mm_outstanding_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CW              (OCW)
    ) u_outstanding (
        .clock       (clock),
        .ctrl_reset  (ctrl_reset),
        .i_inc       (w_rd_acc),
        .i_dec       (w_rv),
        .o_next      (w_out_next),
        .o_full      (w_full),
        .o_dec_taken (w_ret)
    );

    assign w_next_full = (w_out_next == OCW'(MAX_OUTSTANDING));
    assign w_sum_nxt   = w_ret ? r_sum + bus.m_readdata : r_sum;
    assign w_err_nxt   = (w_ret && (bus.m_readdata != r_exp) && (r_errors != '1))
                         ? r_errors + CNT_W'(1) : r_errors;

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_state       <= st_idle;
            r_count       <= '0;
            r_idx         <= '0;
            r_errors      <= '0;
            r_done_errors <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_exp         <= '0;
            r_sum         <= '0;
            r_done_sum    <= '0;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                st_idle: begin
                    if (bus.cmd_valid) begin
                        r_count  <= bus.cmd_count;
                        r_idx    <= '0;
                        r_addr   <= {bus.cmd_base[ADDR_W-1:2], 2'b00};
                        r_wdata  <= bus.cmd_seed;
                        r_exp    <= bus.cmd_seed;
                        r_sum    <= '0;
                        r_errors <= '0;
                        r_busy   <= 1'b1;
                        if (bus.cmd_count == '0) begin
                            r_state       <= st_done;
                            r_done        <= 1'b1;
                            r_done_sum    <= '0;
                            r_done_errors <= '0;
                        end else if (bus.cmd_op == OP_CHECK) begin
                            r_state <= st_read;
                            r_read  <= 1'b1;
                        end else begin
                            r_state <= st_write;
                            r_write <= 1'b1;
                        end
                    end
                end
                st_write: begin
                    if (w_wr_acc) begin
                        if (w_last) begin
                            r_write       <= 1'b0;
                            r_state       <= st_done;
                            r_done        <= 1'b1;
                            r_done_sum    <= '0;
                            r_done_errors <= '0;
                        end else begin
                            r_idx   <= r_idx + CNT_W'(1);
                            r_addr  <= r_addr + ADDR_W'(WORD_STRIDE);
                            r_wdata <= r_wdata + DATA_W'(1);
                        end
                    end
                end
                st_read: begin
                    if (w_rd_acc && w_last) begin
                        r_read  <= 1'b0;
                        r_state <= st_drain;
                    end else if (w_rd_acc) begin
                        r_idx  <= r_idx + CNT_W'(1);
                        r_addr <= r_addr + ADDR_W'(WORD_STRIDE);
                        r_read <= !w_next_full;
                    end else if (!r_read) begin
                        // Idle slot: re-raise only if a return frees a full window.
                        r_read <= !(w_full && !w_ret);
                    end
                end
                st_drain: begin
                    if (w_out_next == '0) begin
                        r_state       <= st_done;
                        r_done        <= 1'b1;
                        r_done_sum    <= w_sum_nxt;
                        r_done_errors <= w_err_nxt;
                    end
                end
                st_done: begin
                    r_state <= st_idle;
                    r_busy  <= 1'b0;
                end
                default: r_state <= st_idle;
            endcase

            if (w_ret) begin
                r_sum    <= w_sum_nxt;
                r_errors <= w_err_nxt;
                r_exp    <= r_exp + DATA_W'(1);
            end
        end
    end

    assign bus.cmd_ready    = (r_state == st_idle);
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.done_sum     = r_done_sum;
    assign bus.done_errors  = r_done_errors;
    assign bus.m_address    = r_addr;
    assign bus.m_read       = r_read;
    assign bus.m_write      = r_write;
    assign bus.m_writedata  = r_wdata;
    assign bus.m_byteenable = '1;

endmodule

// File: tb/tb_hist_mm_master.sv
// Directed bench for hist_mm_master with a fixed-latency RAM responder model.
module tb_hist_mm_master;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int MAXO   = 4;

    logic clock = 1'b0;
    logic ctrl_reset = 1'b1;
    always #5 clock = ~clock;

    hist_mm_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    hist_mm_master #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .CNT_W           (CNT_W),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Responder model: memory indexed by address[7:2], returns after lat cycles.
    typedef struct {
        logic [31:0] data;
        int          due;
    } ret_t;

    logic [31:0] mem [64];
    ret_t        rq [$];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_edge [$];
    int          rd_edge [$];
    int          cyc = 0;
    int          lat = 2;
    bit          randwait = 1'b0;
    bit          chk_out = 1'b0;
    int          max_pend = 0;

    logic        prev_wait = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_rst = 1'b1;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wd = '0;
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        int   k;
        logic w;
        ret_t r;
        k = cyc + 1;
        if (prev_wait && prev_req && !prev_rst) begin
            check("stall_addr", 64'(bus.m_address), 64'(prev_addr));
            check("stall_wdata", 64'(bus.m_writedata), 64'(prev_wd));
            check("stall_read", 64'(bus.m_read), 64'(prev_rd));
            check("stall_write", 64'(bus.m_write), 64'(prev_wr));
        end
        if (bus.m_read || bus.m_write)
            check("rd_wr_excl", 64'(bus.m_read & bus.m_write), 64'd0);
        if (chk_out) begin
            if (rq.size() > max_pend) max_pend = rq.size();
            check("pend_le_max", 64'(rq.size() <= MAXO), 64'd1);
            if (rq.size() == MAXO)
                check("read_low_when_full", 64'(bus.m_read), 64'd0);
        end
        w = randwait ? ($urandom_range(0, 1) == 1) : 1'b0;
        bus.m_waitrequest = w;
        if (!ctrl_reset && !w) begin
            if (bus.m_write) begin
                mem[bus.m_address[7:2]] = bus.m_writedata;
                wr_addr.push_back(bus.m_address);
                wr_data.push_back(bus.m_writedata);
                wr_edge.push_back(k);
            end
            if (bus.m_read) begin
                r.data = mem[bus.m_address[7:2]];
                r.due  = k + lat;
                rq.push_back(r);
                rd_edge.push_back(k);
            end
        end
        if (rq.size() > 0 && rq[0].due == k) begin
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata      = rq[0].data;
            void'(rq.pop_front());
        end else begin
            bus.m_readdatavalid = 1'b0;
            bus.m_readdata      = 32'hDEAD_BEEF;
        end
        prev_wait = w;
        prev_req  = bus.m_read | bus.m_write;
        prev_rst  = ctrl_reset;
        prev_addr = bus.m_address;
        prev_wd   = bus.m_writedata;
        prev_rd   = bus.m_read;
        prev_wr   = bus.m_write;
    end

    // n = cycle index (relative to accept cycle T) in which done is seen.
    task automatic run_cmd(input logic op, input logic [31:0] base, input logic [15:0] cnt,
                           input logic [31:0] seed, output int n, output int t0);
        wr_addr.delete();
        wr_data.delete();
        wr_edge.delete();
        rd_edge.delete();
        @(posedge clock); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_base  = base;
        bus.cmd_count = cnt;
        bus.cmd_seed  = seed;
        @(posedge clock); #1;
        t0 = cyc;
        bus.cmd_valid = 1'b0;
        n = 0;
        do begin
            n++;
            @(negedge clock);
            if (!bus.done && n < 2000) @(posedge clock);
        end while (!bus.done && n < 2000);
        check("done_seen", 64'(bus.done), 64'd1);
        check("busy_in_done", 64'(bus.busy), 64'd1);
    endtask

    initial begin
        int n;
        int t0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_count = '0;
        bus.cmd_seed  = '0;
        bus.m_waitrequest   = 1'b0;
        bus.m_readdatavalid = 1'b0;
        bus.m_readdata      = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_m_read", 64'(bus.m_read), 64'd0);
        check("rst_m_write", 64'(bus.m_write), 64'd0);
        check("rst_address", 64'(bus.m_address), 64'd0);
        check("rst_wdata", 64'(bus.m_writedata), 64'd0);
        check("rst_sum", 64'(bus.done_sum), 64'd0);
        check("rst_errors", 64'(bus.done_errors), 64'd0);
        check("byteenable", 64'(bus.m_byteenable), 64'hF);
        ctrl_reset = 1'b0;

        // FILL 8 words at 0x0, seed 0x100
        run_cmd(1'b0, 32'h0, 16'd8, 32'h100, n, t0);
        check("fill8_done_cycle", 64'(n), 64'd9);
        check("fill8_nwrites", 64'(wr_addr.size()), 64'd8);
        for (int i = 0; i < wr_addr.size(); i++) begin
            check("fill8_addr", 64'(wr_addr[i]), 64'(4 * i));
            check("fill8_data", 64'(wr_data[i]), 64'(32'h100 + i));
            check("fill8_edge", 64'(wr_edge[i]), 64'(t0 + 1 + i));
        end
        check("fill8_nreads", 64'(rd_edge.size()), 64'd0);
        check("fill8_sum", 64'(bus.done_sum), 64'd0);
        check("fill8_errors", 64'(bus.done_errors), 64'd0);
        @(negedge clock);
        check("after_done_low", 64'(bus.done), 64'd0);
        check("after_busy_low", 64'(bus.busy), 64'd0);
        check("after_ready", 64'(bus.cmd_ready), 64'd1);

        // CHECK same range, latency 2, no stalls: back-to-back reads
        lat = 2;
        run_cmd(1'b1, 32'h0, 16'd8, 32'h100, n, t0);
        check("chk8_done_cycle", 64'(n), 64'd11);
        check("chk8_nreads", 64'(rd_edge.size()), 64'd8);
        for (int i = 0; i < rd_edge.size(); i++)
            check("chk8_read_edge", 64'(rd_edge[i]), 64'(t0 + 1 + i));
        check("chk8_sum", 64'(bus.done_sum), 64'h81C);
        check("chk8_errors", 64'(bus.done_errors), 64'd0);

        // Random stalls with word 3 corrupted
        mem[3] = 32'h0;
        randwait = 1'b1;
        run_cmd(1'b1, 32'h0, 16'd8, 32'h100, n, t0);
        randwait = 1'b0;
        check("stall_nreads", 64'(rd_edge.size()), 64'd8);
        check("stall_sum", 64'(bus.done_sum), 64'h719);
        check("stall_errors", 64'(bus.done_errors), 64'd1);
        @(negedge clock);
        check("hold_sum", 64'(bus.done_sum), 64'h719);
        check("hold_errors", 64'(bus.done_errors), 64'd1);

        // 16 words, latency 8: window limited to MAXO
        run_cmd(1'b0, 32'h80, 16'd16, 32'h200, n, t0);
        check("fill16_done_cycle", 64'(n), 64'd17);
        lat = 8;
        max_pend = 0;
        chk_out = 1'b1;
        run_cmd(1'b1, 32'h80, 16'd16, 32'h200, n, t0);
        chk_out = 1'b0;
        check("chk16_max_pend", 64'(max_pend), 64'(MAXO));
        check("chk16_nreads", 64'(rd_edge.size()), 64'd16);
        check("chk16_sum", 64'(bus.done_sum), 64'h2078);
        check("chk16_errors", 64'(bus.done_errors), 64'd0);

        // Zero-length command
        lat = 2;
        run_cmd(1'b1, 32'h0, 16'd0, 32'h100, n, t0);
        check("zero_done_cycle", 64'(n), 64'd1);
        check("zero_nreads", 64'(rd_edge.size()), 64'd0);
        check("zero_nwrites", 64'(wr_addr.size()), 64'd0);
        check("zero_sum", 64'(bus.done_sum), 64'd0);

        // Address wrap, low base bits ignored
        run_cmd(1'b0, 32'hFFFF_FFFB, 16'd4, 32'h55, n, t0);
        check("wrap_done_cycle", 64'(n), 64'd5);
        check("wrap_nwrites", 64'(wr_addr.size()), 64'd4);
        if (wr_addr.size() == 4) begin
            check("wrap_addr0", 64'(wr_addr[0]), 64'hFFFF_FFF8);
            check("wrap_addr1", 64'(wr_addr[1]), 64'hFFFF_FFFC);
            check("wrap_addr2", 64'(wr_addr[2]), 64'h0);
            check("wrap_addr3", 64'(wr_addr[3]), 64'h4);
            check("wrap_data3", 64'(wr_data[3]), 64'h58);
        end

        // Reset with 3 reads pending, then normal operation
        lat = 8;
        @(posedge clock); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b1;
        bus.cmd_base  = 32'h80;
        bus.cmd_count = 16'd16;
        bus.cmd_seed  = 32'h200;
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 50 && rq.size() != 3; i++) begin
            @(posedge clock); #1;
        end
        check("rst_pend3", 64'(rq.size()), 64'd3);
        ctrl_reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrst_m_read", 64'(bus.m_read), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_ready", 64'(bus.cmd_ready), 64'd1);
        check("midrst_addr", 64'(bus.m_address), 64'd0);
        ctrl_reset = 1'b0;
        lat = 2;
        run_cmd(1'b0, 32'h40, 16'd2, 32'hA0, n, t0);
        check("postrst_fill_cycle", 64'(n), 64'd3);
        check("postrst_fill_sum", 64'(bus.done_sum), 64'd0);
        check("postrst_fill_err", 64'(bus.done_errors), 64'd0);
        for (int i = 0; i < 40 && rq.size() != 0; i++) @(negedge clock);
        check("late_drained", 64'(rq.size()), 64'd0);
        run_cmd(1'b1, 32'h40, 16'd2, 32'hA0, n, t0);
        check("postrst_chk_cycle", 64'(n), 64'd5);
        check("postrst_chk_sum", 64'(bus.done_sum), 64'h141);
        check("postrst_chk_err", 64'(bus.done_errors), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
